// File: rtl/seven_segment_scan_hex_pkg.sv
// rtl/seven_segment_scan_hex_pkg.sv - shared display constants and the leading-digit helper
package seven_segment_scan_hex_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF = 4'hF;

  // Index of the highest non-zero nibble; an all-zero value reports digit 0.
  function automatic logic [1:0] top_digit(input logic [15:0] v);
    logic [1:0] top;
    top = 2'd0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (v[k*4 +: 4] != 4'h0) top = k[1:0];
    end
    return top;
  endfunction

endpackage

// File: rtl/Seven_Segment_Display_Hex.sv
// rtl/Seven_Segment_Display_Hex.sv - hex nibble to active-low segments, seg[6:0] = {g,f,e,d,c,b,a}
module Seven_Segment_Display_Hex (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seven_segment_scan_hex.sv
// rtl/seven_segment_scan_hex.sv - four-digit multiplexed hex display with frame-aligned value updates
module seven_segment_scan_hex
  import seven_segment_scan_hex_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYC    = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        lz_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] DEAD = CW'(DEAD_CYC);
  localparam logic [IW-1:0] LAST_DIGIT = IW'(NUM_DIGITS - 1);

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [15:0]   active;
  logic [15:0]   pending;
  logic          pend_flag;
  logic          tick;
  logic          boundary;
  logic          blank;
  logic [3:0]    nib;
  logic [6:0]    dec_seg;

  assign tick     = (cnt == LAST);
  assign boundary = tick && (idx == LAST_DIGIT);
  assign nib      = active[{idx, 2'b00} +: 4];

  // Blanking looks only at the committed value so a frame never mixes old and new digits.
  always_comb begin
    blank = 1'b0;
    if (cnt < DEAD) blank = 1'b1;
    else if (lz_en && (idx > top_digit(active))) blank = 1'b1;
  end

  Seven_Segment_Display_Hex u_dec (
    .hex (nib),
    .seg (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      active     <= 16'h0000;
      pending    <= 16'h0000;
      pend_flag  <= 1'b0;
      an         <= AN_OFF;
      seg        <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      cnt        <= tick ? '0 : cnt + 1'b1;
      frame_done <= boundary;
      if (tick) idx <= idx + 1'b1;
      if (boundary && pend_flag) active <= pending;
      // A load on the boundary cycle re-arms the flag, so it waits for the next frame.
      if (load) begin
        pending   <= value;
        pend_flag <= 1'b1;
      end else if (boundary) begin
        pend_flag <= 1'b0;
      end
      an  <= blank ? AN_OFF : ~(4'b0001 << idx);
      seg <= blank ? SEG_BLANK : dec_seg;
    end
  end

endmodule
